// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue to instruction memory, in-order
// response queue toward decode, and redirect handling that drops stale in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      inst_d [DEPTH];
    logic [31:0]      pc_q [DEPTH];
    logic [31:0]      pc_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [31:0]      hold_inst_q, hold_inst_d;
    logic [31:0]      hold_pc_q, hold_pc_d;

    logic             credit_ok;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic             full;
    logic             not_empty;
    logic [31:0]      redirect_aligned;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and flow-control terms
    always_comb begin
        not_empty        = (count_q != '0);
        full             = (count_q == CNT_W'(DEPTH));
        credit_ok        = (SUM_W'(count_q) + SUM_W'(out_q)) < SUM_W'(DEPTH);
        imem_req_valid   = !rst && !redirect_valid && credit_ok;
        imem_req_addr    = fetch_pc_q;
        req_fire         = imem_req_valid && imem_req_ready;
        id_valid         = !rst && not_empty && !redirect_valid;
        pop              = id_valid && id_ready;
        push             = imem_rsp_valid && !redirect_valid && (drop_q == '0);
        redirect_aligned = {redirect_pc[31:2], 2'b00};
        id_inst          = not_empty ? inst_q[rd_ptr_q] : hold_inst_q;
        id_pc            = not_empty ? pc_q[rd_ptr_q]   : hold_pc_q;
    end

    // Next-state
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        drop_d      = drop_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        out_d       = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_d     = out_d;
            if (not_empty) begin
                hold_inst_d = inst_q[rd_ptr_q];
                hold_pc_d   = pc_q[rd_ptr_q];
            end
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push) begin
                inst_d[wr_ptr_q] = imem_rsp_data;
                pc_d[wr_ptr_q]   = rsp_pc_q;
                wr_ptr_d         = ptr_inc(wr_ptr_q);
                rsp_pc_d         = rsp_pc_q + 32'd4;
            end
            // Popped head is kept so id_* hold once the queue runs dry
            if (pop) begin
                hold_inst_d = inst_q[rd_ptr_q];
                hold_pc_d   = pc_q[rd_ptr_q];
                rd_ptr_d    = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_q       <= '0;
            drop_q      <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    // Credit accounting must make overflow impossible
    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized-scoreboard bench for fetch_unit with an in-order memory model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int first_req_cyc = -1;
    int first_id_cyc = -1;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] req_log[$];
    logic [31:0] xfer_pc[$];
    logic [31:0] xfer_inst[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic clear_logs();
        q_addr.delete();
        q_due.delete();
        req_log.delete();
        xfer_pc.delete();
        xfer_inst.delete();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        clear_logs();
        repeat (3) @(negedge clk);
        rst           = 1'b0;
        cyc           = 0;
        first_req_cyc = -1;
        first_id_cyc  = -1;
    endtask

    // One clock cycle: drive memory response, record handshakes, advance to next negedge
    task automatic step();
        int due;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + lat;
            if (q_due.size() > 0 && q_due[$] >= due) due = q_due[$] + 1;
            q_addr.push_back(imem_req_addr);
            q_due.push_back(due);
            req_log.push_back(imem_req_addr);
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (id_valid && first_id_cyc < 0) first_id_cyc = cyc;
        if (id_valid && id_ready) begin
            xfer_pc.push_back(id_pc);
            xfer_inst.push_back(id_inst);
        end
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        cyc++;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        clear_logs();
        repeat (2) @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 0", imem_req_addr); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid got %b want 1", imem_req_valid); end
        @(negedge clk);
    endtask

    task automatic test_sequential();
        do_reset();
        lat = 1;
        repeat (20) step();
        checks++; if (first_req_cyc != 0) begin errors++; $display("FAIL seq_first_req got %0d want 0", first_req_cyc); end
        checks++; if (first_id_cyc != 2) begin errors++; $display("FAIL seq_first_id_valid got %0d want 2", first_id_cyc); end
        checks++;
        if (req_log.size() < 4) begin
            errors++; $display("FAIL seq_req_count got %0d want >=4", req_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (req_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_req_addr[%0d] got %h want %h", i, req_log[i], 32'(4 * i)); end
            end
        end
        checks++; if (xfer_pc.size() < 5) begin errors++; $display("FAIL seq_xfer_count got %0d want >=5", xfer_pc.size()); end
        for (int i = 0; i < xfer_pc.size(); i++) begin
            checks++;
            if (xfer_pc[i] !== 32'(4 * i) || xfer_inst[i] !== inst_of(32'(4 * i))) begin
                errors++; $display("FAIL seq_xfer[%0d] got pc %h inst %h want pc %h inst %h", i, xfer_pc[i], xfer_inst[i], 32'(4 * i), inst_of(32'(4 * i)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat      = 1;
        id_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (id_valid) begin
                checks++;
                if (id_pc !== 32'h0 || id_inst !== inst_of(32'h0)) begin
                    errors++; $display("FAIL stall_hold cyc %0d got pc %h inst %h want pc 0 inst %h", cyc, id_pc, id_inst, inst_of(32'h0));
                end
            end
        end
        checks++; if (req_log.size() != DEPTH) begin errors++; $display("FAIL stall_req_count got %0d want %0d", req_log.size(), DEPTH); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got %b want 0", imem_req_valid); end
        checks++; if (xfer_pc.size() != 0) begin errors++; $display("FAIL stall_no_xfer got %0d want 0", xfer_pc.size()); end
        id_ready = 1'b1;
        repeat (20) step();
        checks++; if (xfer_pc.size() < 6) begin errors++; $display("FAIL stall_resume_count got %0d want >=6", xfer_pc.size()); end
        for (int i = 0; i < xfer_pc.size(); i++) begin
            checks++;
            if (xfer_pc[i] !== 32'(4 * i) || xfer_inst[i] !== inst_of(32'(4 * i))) begin
                errors++; $display("FAIL stall_resume[%0d] got pc %h inst %h want pc %h", i, xfer_pc[i], xfer_inst[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        lat = 3;
        repeat (2) step();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_credit_full got %b want 0", imem_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        repeat (14) step();
        checks++;
        if (req_log.size() < 3) begin
            errors++; $display("FAIL drop_req_count got %0d want >=3", req_log.size());
        end else if (req_log[2] !== 32'h100) begin
            errors++; $display("FAIL drop_req_after got %h want 00000100", req_log[2]);
        end
        checks++;
        if (xfer_pc.size() < 2) begin
            errors++; $display("FAIL drop_xfer_count got %0d want >=2", xfer_pc.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (xfer_pc[i] !== 32'h100 + 32'(4 * i) || xfer_inst[i] !== inst_of(32'h100 + 32'(4 * i))) begin
                    errors++; $display("FAIL drop_xfer[%0d] got pc %h inst %h want pc %h", i, xfer_pc[i], xfer_inst[i], 32'h100 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        lat = 1;
        repeat (3) step();
        xfer_pc.delete();
        xfer_inst.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL misalign_req_addr got %h want 00000200", imem_req_addr); end
        repeat (10) step();
        checks++;
        if (xfer_pc.size() < 2) begin
            errors++; $display("FAIL misalign_xfer_count got %0d want >=2", xfer_pc.size());
        end else if (xfer_pc[0] !== 32'h200 || xfer_pc[1] !== 32'h204 || xfer_inst[0] !== inst_of(32'h200)) begin
            errors++; $display("FAIL misalign_xfer got %h %h want 00000200 00000204", xfer_pc[0], xfer_pc[1]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [3];
        exp_pcs[0] = 32'hFFFF_FFF8;
        exp_pcs[1] = 32'hFFFF_FFFC;
        exp_pcs[2] = 32'h0000_0000;
        do_reset();
        lat = 2;
        repeat (4) step();
        xfer_pc.delete();
        xfer_inst.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        repeat (16) step();
        checks++;
        if (xfer_pc.size() < 3) begin
            errors++; $display("FAIL wrap_xfer_count got %0d want >=3", xfer_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (xfer_pc[i] !== exp_pcs[i] || xfer_inst[i] !== inst_of(exp_pcs[i])) begin
                    errors++; $display("FAIL wrap_xfer[%0d] got pc %h inst %h want pc %h", i, xfer_pc[i], xfer_inst[i], exp_pcs[i]);
                end
            end
        end
    endtask

    task automatic test_hold_empty();
        do_reset();
        lat = 1;
        repeat (8) step();
        imem_req_ready = 1'b0;
        repeat (8) step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL hold_id_valid got %b want 0", id_valid); end
        checks++;
        if (xfer_pc.size() == 0) begin
            errors++; $display("FAIL hold_xfer_count got 0 want >0");
        end else if (id_pc !== xfer_pc[$] || id_inst !== xfer_inst[$]) begin
            errors++; $display("FAIL hold_values got pc %h inst %h want pc %h inst %h", id_pc, id_inst, xfer_pc[$], xfer_inst[$]);
        end
        imem_req_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 2;
        repeat (5) step();
        rst = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL midrst_valids got req %b id %b want 0 0", imem_req_valid, id_valid); end
        checks++; if (id_pc !== 32'h0 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL midrst_regs got id_pc %h addr %h want 0 0", id_pc, imem_req_addr); end
        @(negedge clk);
        do_reset();
        lat = 2;
        repeat (12) step();
        checks++;
        if (xfer_pc.size() == 0 || req_log.size() == 0) begin
            errors++; $display("FAIL midrst_restart got xfers %0d reqs %0d want >0", xfer_pc.size(), req_log.size());
        end else if (xfer_pc[0] !== 32'h0 || req_log[0] !== 32'h0) begin
            errors++; $display("FAIL midrst_restart got pc %h addr %h want 0 0", xfer_pc[0], req_log[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] got_pc;
        logic [31:0] got_inst;
        logic        redir;
        int          total;
        do_reset();
        exp_pc = 32'h0;
        total  = 0;
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(1, 4);
            redir          = ($urandom_range(0, 24) == 0);
            redirect_valid = redir;
            if (redir) redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step();
            while (xfer_pc.size() > 0) begin
                got_pc   = xfer_pc.pop_front();
                got_inst = xfer_inst.pop_front();
                total++;
                checks++;
                if (got_pc !== exp_pc || got_inst !== inst_of(exp_pc)) begin
                    errors++; $display("FAIL rand_xfer cyc %0d got pc %h inst %h want pc %h inst %h", cyc, got_pc, got_inst, exp_pc, inst_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) exp_pc = {redirect_pc[31:2], 2'b00};
            redirect_valid = 1'b0;
        end
        checks++; if (total < 50) begin errors++; $display("FAIL rand_progress got %0d want >=50", total); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_misaligned();
        test_wrap();
        test_hold_empty();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction queue entries and maximum outstanding memory requests (legal range 2..4).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts the request when valid and ready are both high.
REQ-007 imem_req_addr  out  32  word-aligned fetch address; bits [1:0] always 0.
REQ-008 imem_rsp_valid  in  1  response valid for one cycle; responses are in request order, latency at least 1 cycle, no backpressure.
REQ-009 imem_rsp_data  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  taken branch/jump from execute; single-cycle pulse.
REQ-011 redirect_pc  in  32  new fetch target; bits [1:0] ignored and treated as 0.
REQ-012 id_valid  out  1  decode-bound instruction valid.
REQ-013 id_ready  in  1  decode accepts; a transfer occurs when id_valid and id_ready are both high.
REQ-014 id_inst  out  32  instruction at queue head; decode slices the immediate fields from it.
REQ-015 id_pc  out  32  address of id_inst.

Function
REQ-016 State: fetch_pc (next request address), rsp_pc (address of the next kept response), DEPTH-entry FIFO of {inst, pc}, outstanding counter, drop counter.
REQ-017 imem_req_valid = !rst && !redirect_valid && (occupancy + outstanding < DEPTH); imem_req_addr = fetch_pc.
REQ-018 On a request handshake: fetch_pc += 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000, and outstanding increments.
REQ-019 On any response: outstanding decrements; a same-cycle request handshake nets to no change in outstanding.
REQ-020 When drop counter > 0, the response is discarded and the drop counter decrements.
REQ-021 When drop counter = 0, {imem_rsp_data, rsp_pc} is pushed into the FIFO and rsp_pc += 4 with the same wrap.
REQ-022 No bypass: a pushed entry is first visible on id_* the cycle after the response.
REQ-023 id_valid = FIFO non-empty && !redirect_valid; id_inst and id_pc show the head entry and hold stable while id_valid && !id_ready.
REQ-024 A decode transfer pops the head; a simultaneous push and pop keeps occupancy unchanged.
REQ-025 The credit rule (REQ-017) guarantees a push never finds the FIFO full; a push into a full FIFO is an assertion failure.
REQ-026 Redirect (highest priority) on the next edge: FIFO emptied; fetch_pc and rsp_pc <= {redirect_pc[31:2], 2'b00}.
REQ-027 Redirect on the next edge: drop counter <= outstanding minus 1 if a response arrives in the redirect cycle, else outstanding; no request is issued in the redirect cycle.
REQ-028 A response arriving in the redirect cycle is always discarded, regardless of drop counter value.
REQ-029 A redirect arriving while drop counter > 0 recomputes the drop counter per REQ-027; new requests may issue while drops are pending.
REQ-030 Empty FIFO with id_ready high: no transfer, and id_inst/id_pc hold their last values.

Reset
REQ-031 While rst is high: fetch_pc = rsp_pc = RESET_PC, FIFO empty, both counters 0.
REQ-032 While rst is high: imem_req_valid = 0, id_valid = 0, imem_req_addr = RESET_PC, id_inst = 0, id_pc = 0.
REQ-033 Reset asserted mid-operation abandons in-flight requests; the memory model is reset together with the block.
REQ-034 First request asserts in the first cycle after rst deasserts.

Verification
REQ-035 Reset release, ready=1, latency 1: requests at 0x0,0x4,0x8..., id_inst/id_pc sequence matches, id_valid first high 2 cycles after first request.
REQ-036 id_ready=0 for 10 cycles: exactly DEPTH requests issued, then imem_req_valid=0; id_inst/id_pc stable; resumes on id_ready=1 with no loss or duplication.
REQ-037 Latency 3, two outstanding, redirect_pc=0x100: both stale responses dropped, next id_pc=0x100, then 0x104.
REQ-038 redirect_pc=0x203: imem_req_addr=0x200, first id_pc=0x200.
REQ-039 Redirect to 0xFFFF_FFF8: id_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-040 Random ready/latency/redirects with a scoreboard: every id_pc follows program order from the last redirect, with no stale instruction delivered.
